// File: rtl/srec_word_writer.sv
// Merges S-record parser byte writes into 32-bit word writes with byte enables,
// buffers them in a small FIFO and drains it to memory over a req/ack handshake.
module srec_word_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] byte_address,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        in_progress,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic        asm_valid_q, asm_valid_d;
    logic [29:0] asm_addr_q,  asm_addr_d;
    logic [31:0] asm_data_q,  asm_data_d;
    logic [3:0]  asm_be_q,    asm_be_d;
    logic        flush_pend_q, flush_pend_d;
    logic        in_progress_q, in_progress_d;
    logic        overflow_q,  overflow_d;
    logic [15:0] word_count_q, word_count_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

    logic [29:0] fifo_addr_q [FIFO_DEPTH];
    logic [29:0] fifo_addr_d [FIFO_DEPTH];
    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] fifo_data_d [FIFO_DEPTH];
    logic [3:0]  fifo_be_q   [FIFO_DEPTH];
    logic [3:0]  fifo_be_d   [FIFO_DEPTH];

    logic [1:0]     lane;
    logic [3:0]     lane_oh;
    logic [31:0]    lane_data;
    logic [31:0]    lane_mask;
    logic [31:0]    merged_data;
    logic [3:0]     merged_be;
    logic           hit;
    logic           flush_req;
    logic           push;
    logic [29:0]    push_addr;
    logic [31:0]    push_data;
    logic [3:0]     push_be;
    logic [PTR_W:0] fifo_count;
    logic           fifo_full;
    logic           fifo_nonempty;
    logic           pop;

    always_comb begin
        lane        = byte_address[1:0] ^ {2{BIG_ENDIAN}};
        lane_oh     = 4'b0001 << lane;
        lane_data   = 32'(byte_data) << {lane, 3'b000};
        lane_mask   = 32'h0000_00FF << {lane, 3'b000};
        merged_data = (asm_data_q & ~lane_mask) | lane_data;
        merged_be   = asm_be_q | lane_oh;
        hit         = asm_valid_q && (byte_address[31:2] == asm_addr_q) &&
                      ((asm_be_q & lane_oh) == 4'b0000);
        // A deferred flush (from a miss+flush cycle) behaves like a fresh flush request.
        flush_req   = flush || (in_progress_q && !in_progress) || flush_pend_q;

        fifo_count    = wr_ptr_q - rd_ptr_q;
        fifo_full     = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
        fifo_nonempty = (fifo_count != '0);
        pop           = fifo_nonempty && mem_ack;

        asm_valid_d   = asm_valid_q;
        asm_addr_d    = asm_addr_q;
        asm_data_d    = asm_data_q;
        asm_be_d      = asm_be_q;
        flush_pend_d  = 1'b0;
        in_progress_d = in_progress;
        push          = 1'b0;
        push_addr     = asm_addr_q;
        push_data     = asm_data_q;
        push_be       = asm_be_q;

        if (byte_valid) begin
            if (hit) begin
                if (merged_be == 4'hF || flush_req) begin
                    push        = 1'b1;
                    push_data   = merged_data;
                    push_be     = merged_be;
                    asm_valid_d = 1'b0;
                    asm_data_d  = '0;
                    asm_be_d    = '0;
                end else begin
                    asm_data_d = merged_data;
                    asm_be_d   = merged_be;
                end
            end else begin
                push        = asm_valid_q;
                asm_valid_d = 1'b1;
                asm_addr_d  = byte_address[31:2];
                asm_data_d  = lane_data;
                asm_be_d    = lane_oh;
                // Only one push per cycle: the new one-byte word waits a cycle if the old one went out.
                if (flush_req) begin
                    if (asm_valid_q) begin
                        flush_pend_d = 1'b1;
                    end else begin
                        push        = 1'b1;
                        push_addr   = byte_address[31:2];
                        push_data   = lane_data;
                        push_be     = lane_oh;
                        asm_valid_d = 1'b0;
                        asm_data_d  = '0;
                        asm_be_d    = '0;
                    end
                end
            end
        end else if (flush_req && asm_valid_q) begin
            push        = 1'b1;
            asm_valid_d = 1'b0;
            asm_data_d  = '0;
            asm_be_d    = '0;
        end

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        fifo_be_d    = fifo_be_q;

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            word_count_d = word_count_q + 16'd1;
        end
        if (push) begin
            if (!fifo_full || pop) begin
                fifo_addr_d[wr_ptr_q[PTR_W-1:0]] = push_addr;
                fifo_data_d[wr_ptr_q[PTR_W-1:0]] = push_data;
                fifo_be_d[wr_ptr_q[PTR_W-1:0]]   = push_be;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_valid_q   <= 1'b0;
            asm_addr_q    <= '0;
            asm_data_q    <= '0;
            asm_be_q      <= '0;
            flush_pend_q  <= 1'b0;
            in_progress_q <= 1'b0;
            overflow_q    <= 1'b0;
            word_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_addr_q   <= '{default: '0};
            fifo_data_q   <= '{default: '0};
            fifo_be_q     <= '{default: '0};
        end else begin
            asm_valid_q   <= asm_valid_d;
            asm_addr_q    <= asm_addr_d;
            asm_data_q    <= asm_data_d;
            asm_be_q      <= asm_be_d;
            flush_pend_q  <= flush_pend_d;
            in_progress_q <= in_progress_d;
            overflow_q    <= overflow_d;
            word_count_q  <= word_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_addr_q   <= fifo_addr_d;
            fifo_data_q   <= fifo_data_d;
            fifo_be_q     <= fifo_be_d;
        end
    end

    always_comb begin
        mem_req     = fifo_nonempty;
        mem_address = fifo_nonempty ? {fifo_addr_q[rd_ptr_q[PTR_W-1:0]], 2'b00} : '0;
        mem_wdata   = fifo_nonempty ? fifo_data_q[rd_ptr_q[PTR_W-1:0]] : '0;
        mem_be      = fifo_nonempty ? fifo_be_q[rd_ptr_q[PTR_W-1:0]] : '0;
        busy        = asm_valid_q || fifo_nonempty;
        overflow    = overflow_q;
        word_count  = word_count_q;
    end

endmodule

// File: tb/tb_srec_word_writer.sv
// Directed bench for srec_word_writer: a little-endian and a big-endian instance
// share stimulus; accepted memory writes are logged and checked against hand values.
module tb_srec_word_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] byte_address;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        in_progress;
    logic        flush;
    logic        mem_ack;

    logic        mem_req, busy, overflow;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] word_count;

    logic        b_mem_req, b_busy, b_overflow;
    logic [31:0] b_mem_address, b_mem_wdata;
    logic [3:0]  b_mem_be;
    logic [15:0] b_word_count;

    int checks = 0;
    int errors = 0;
    int exp_wc = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];
    logic [31:0] blog_addr[$];
    logic [31:0] blog_data[$];
    logic [3:0]  blog_be[$];

    always #5 clock = ~clock;

    srec_word_writer #(.FIFO_DEPTH(4), .BIG_ENDIAN(1'b0)) dut (
        .clock(clock), .reset(reset),
        .byte_address(byte_address), .byte_data(byte_data), .byte_valid(byte_valid),
        .in_progress(in_progress), .flush(flush),
        .mem_req(mem_req), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack),
        .busy(busy), .overflow(overflow), .word_count(word_count)
    );

    srec_word_writer #(.FIFO_DEPTH(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clock(clock), .reset(reset),
        .byte_address(byte_address), .byte_data(byte_data), .byte_valid(byte_valid),
        .in_progress(in_progress), .flush(flush),
        .mem_req(b_mem_req), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_be(b_mem_be), .mem_ack(mem_ack),
        .busy(b_busy), .overflow(b_overflow), .word_count(b_word_count)
    );

    always @(posedge clock) begin
        if (!reset && mem_req && mem_ack) begin
            log_addr.push_back(mem_address);
            log_data.push_back(mem_wdata);
            log_be.push_back(mem_be);
        end
        if (!reset && b_mem_req && mem_ack) begin
            blog_addr.push_back(b_mem_address);
            blog_data.push_back(b_mem_wdata);
            blog_be.push_back(b_mem_be);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [31:0] a, input logic [7:0] d);
        byte_address = a;
        byte_data    = d;
        byte_valid   = 1'b1;
        tick();
        byte_valid   = 1'b0;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_be.delete();
        blog_addr.delete();
        blog_data.delete();
        blog_be.delete();
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!busy && !b_busy) break;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b busy_be=%b after 100 cycles, required 0", busy, b_busy);
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        checks++;
        if (idx >= log_addr.size()) begin
            errors++;
            $display("FAIL %s: write %0d missing (only %0d writes)", name, idx, log_addr.size());
        end else if (log_addr[idx] !== a || log_data[idx] !== d || log_be[idx] !== be) begin
            errors++;
            $display("FAIL %s: write %0d addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                     name, idx, log_addr[idx], log_data[idx], log_be[idx], a, d, be);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_address !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 ||
            busy !== 1'b0 || overflow !== 1'b0 || word_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h wdata=%h be=%b busy=%b ovf=%b wc=%0d, required all 0",
                     mem_req, mem_address, mem_wdata, mem_be, busy, overflow, word_count);
        end
        in_progress = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        clear_logs();
        mem_ack = 1'b1;
        send_byte(32'h8000_0000, 8'h11);
        send_byte(32'h8000_0001, 8'h22);
        send_byte(32'h8000_0002, 8'h33);
        send_byte(32'h8000_0003, 8'h44);
        checks++;
        if (mem_req !== 1'b1 || mem_address !== 32'h8000_0000 || mem_wdata !== 32'h4433_2211 || mem_be !== 4'hF) begin
            errors++;
            $display("FAIL full_word_req: req=%b addr=%h wdata=%h be=%b, required 1 80000000 44332211 1111",
                     mem_req, mem_address, mem_wdata, mem_be);
        end
        wait_idle();
        exp_wc += 1;
        check_log("full_word_write", 0, 32'h8000_0000, 32'h4433_2211, 4'hF);
        checks++;
        if (log_addr.size() != 1 || word_count !== 16'(exp_wc)) begin
            errors++;
            $display("FAIL full_word_count: writes=%0d wc=%0d, required 1 and %0d", log_addr.size(), word_count, exp_wc);
        end
    endtask

    task automatic test_load_end_flush();
        clear_logs();
        send_byte(32'h0000_0100, 8'hAA);
        send_byte(32'h0000_0101, 8'hBB);
        tick();
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL partial_hold: busy=%b req=%b, required busy=1 req=0", busy, mem_req);
        end
        in_progress = 1'b0;
        tick();
        wait_idle();
        in_progress = 1'b1;
        exp_wc += 1;
        check_log("load_end_write", 0, 32'h0000_0100, 32'h0000_BBAA, 4'b0011);
        checks++;
        if (busy !== 1'b0 || log_addr.size() != 1) begin
            errors++;
            $display("FAIL load_end_idle: busy=%b writes=%0d, required 0 and 1", busy, log_addr.size());
        end
    endtask

    task automatic test_lane_split();
        clear_logs();
        send_byte(32'h0000_0103, 8'h55);
        send_byte(32'h0000_0104, 8'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        exp_wc += 2;
        check_log("split_le_first", 0, 32'h0000_0100, 32'h5500_0000, 4'b1000);
        check_log("split_le_second", 1, 32'h0000_0104, 32'h0000_0066, 4'b0001);
        checks++;
        if (blog_addr.size() != 2) begin
            errors++;
            $display("FAIL split_be_count: writes=%0d, required 2", blog_addr.size());
        end else if (blog_addr[0] !== 32'h100 || blog_data[0] !== 32'h0000_0055 || blog_be[0] !== 4'b0001 ||
                     blog_addr[1] !== 32'h104 || blog_data[1] !== 32'h6600_0000 || blog_be[1] !== 4'b1000) begin
            errors++;
            $display("FAIL split_be_writes: %h/%h/%b then %h/%h/%b, required 100/00000055/0001 then 104/66000000/1000",
                     blog_addr[0], blog_data[0], blog_be[0], blog_addr[1], blog_data[1], blog_be[1]);
        end
    endtask

    task automatic test_same_lane();
        clear_logs();
        send_byte(32'h0000_0200, 8'h01);
        send_byte(32'h0000_0200, 8'h02);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        exp_wc += 2;
        check_log("same_lane_first", 0, 32'h0000_0200, 32'h0000_0001, 4'b0001);
        check_log("same_lane_second", 1, 32'h0000_0200, 32'h0000_0002, 4'b0001);
    endtask

    task automatic test_overflow();
        int stall_bad;
        logic [7:0] b;
        clear_logs();
        stall_bad = 0;
        mem_ack = 1'b0;
        for (int w = 0; w < 24; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(4 * w + k);
                send_byte(32'h0000_1000 + 32'(4 * w + k), b);
                if (mem_req === 1'b1 &&
                    (mem_address !== 32'h0000_1000 || mem_wdata !== 32'h0302_0100 || mem_be !== 4'hF))
                    stall_bad++;
            end
            if (w == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_early: overflow=%b with FIFO just full, required 0", overflow);
                end
            end
            if (w == 4) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow_set: overflow=%b after fifth word, required 1", overflow);
                end
            end
        end
        checks++;
        if (stall_bad != 0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable samples, req=%b, required 0 and 1", stall_bad, mem_req);
        end
        mem_ack = 1'b1;
        wait_idle();
        exp_wc += 4;
        check_log("overflow_w0", 0, 32'h0000_1000, 32'h0302_0100, 4'hF);
        check_log("overflow_w1", 1, 32'h0000_1004, 32'h0706_0504, 4'hF);
        check_log("overflow_w2", 2, 32'h0000_1008, 32'h0B0A_0908, 4'hF);
        check_log("overflow_w3", 3, 32'h0000_100C, 32'h0F0E_0D0C, 4'hF);
        checks++;
        if (log_addr.size() != 4 || overflow !== 1'b1 || b_overflow !== 1'b1 || word_count !== 16'(exp_wc)) begin
            errors++;
            $display("FAIL overflow_drain: writes=%0d ovf=%b ovf_be=%b wc=%0d, required 4 1 1 %0d",
                     log_addr.size(), overflow, b_overflow, word_count, exp_wc);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        mem_ack = 1'b0;
        send_byte(32'h0000_2000, 8'hA0);
        send_byte(32'h0000_2001, 8'hA1);
        send_byte(32'h0000_2002, 8'hA2);
        send_byte(32'h0000_2003, 8'hA3);
        send_byte(32'h0000_3000, 8'hB0);
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: req=%b busy=%b, required 1 1", mem_req, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_wc = 0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || word_count !== 16'h0 || overflow !== 1'b0 ||
            mem_address !== 32'h0 || b_word_count !== 16'h0 || b_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: req=%b busy=%b wc=%0d ovf=%b addr=%h wc_be=%0d ovf_be=%b, required all 0",
                     mem_req, busy, word_count, overflow, mem_address, b_word_count, b_overflow);
        end
        mem_ack = 1'b1;
        in_progress = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_nowrite: writes=%0d, required 0", log_addr.size());
        end
    endtask

    task automatic test_miss_flush();
        clear_logs();
        mem_ack = 1'b1;
        send_byte(32'h0000_0400, 8'h11);
        byte_address = 32'h0000_0408;
        byte_data    = 8'h22;
        byte_valid   = 1'b1;
        flush        = 1'b1;
        tick();
        byte_valid   = 1'b0;
        flush        = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_address !== 32'h0000_0400 || mem_wdata !== 32'h0000_0011 || mem_be !== 4'b0001) begin
            errors++;
            $display("FAIL miss_flush_old: req=%b addr=%h wdata=%h be=%b, required 1 00000400 00000011 0001",
                     mem_req, mem_address, mem_wdata, mem_be);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_address !== 32'h0000_0408 || mem_wdata !== 32'h0000_0022 || mem_be !== 4'b0001) begin
            errors++;
            $display("FAIL miss_flush_new: req=%b addr=%h wdata=%h be=%b, required 1 00000408 00000022 0001",
                     mem_req, mem_address, mem_wdata, mem_be);
        end
        wait_idle();
        exp_wc += 2;
        check_log("miss_flush_w0", 0, 32'h0000_0400, 32'h0000_0011, 4'b0001);
        check_log("miss_flush_w1", 1, 32'h0000_0408, 32'h0000_0022, 4'b0001);
        checks++;
        if (log_addr.size() != 2 || word_count !== 16'(exp_wc)) begin
            errors++;
            $display("FAIL miss_flush_count: writes=%0d wc=%0d, required 2 and %0d", log_addr.size(), word_count, exp_wc);
        end
    endtask

    initial begin
        reset        = 1'b1;
        byte_address = '0;
        byte_data    = '0;
        byte_valid   = 1'b0;
        in_progress  = 1'b0;
        flush        = 1'b0;
        mem_ack      = 1'b0;
        test_reset();
        test_full_word();
        test_load_end_flush();
        test_lane_split();
        test_same_lane();
        test_overflow();
        test_reset_mid();
        test_miss_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
